data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 30 +++
 rtl/data_mem_responder_align.sv | 69 ++++++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I access width codes,
// FSM state encoding and the captured request record.
package Mem_Access_PKG;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [2:0]            funct3;
  } mem_req_t;

endpackage

// File: rtl/data_mem_responder_align.sv
// Combinational lane logic: store byte enables / lane replication, access error
// detection, and load-result extraction with sign or zero extension.
module load_store_align
  import Mem_Access_PKG::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic               code_ok;
  logic               aligned;
  logic [31:0]        rshift;
  logic signed [7:0]  rbyte_s;
  logic signed [15:0] rhalf_s;

  // funct3[1:0] encodes access width for every legal load and store code
  always_comb begin
    code_ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
              (!we && ((funct3 == F3_LBU) || (funct3 == F3_LHU)));
    case (funct3[1:0])
      2'b01:   aligned = !addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    err = !code_ok || !aligned;
  end

  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
    if (!we || err) byte_en = 4'b0000;
  end

  always_comb begin
    rshift    = rword >> {addr_lo, 3'b000};
    rbyte_s   = rshift[7:0];
    rhalf_s   = rshift[15:0];
    rdata_ext = 32'h0;
    if (!we && !err) begin
      case (funct3)
        F3_LB:   rdata_ext = {{24{rbyte_s[7]}}, rbyte_s};
        F3_LH:   rdata_ext = {{16{rhalf_s[15]}}, rhalf_s};
        F3_LW:   rdata_ext = rshift;
        F3_LBU:  rdata_ext = {24'h0, rshift[7:0]};
        F3_LHU:  rdata_ext = {16'h0, rshift[15:0]};
        default: rdata_ext = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency byte-addressable data memory with valid/ready request and
// response channels; one access in flight, committed on the WAIT->RESP edge.
module data_mem_responder
  import Mem_Access_PKG::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int WORDS = 2 ** (DM_ADDRESS - 2);

  state_t              state, state_next;
  logic [3:0]          cnt, cnt_next;
  logic                accept, commit, rsp_done;
  mem_req_t            req_q;
  logic [31:0]         mem [WORDS];
  logic [DM_ADDRESS-3:0] word_idx;
  logic [31:0]         rword;
  logic [3:0]          byte_en;
  logic [31:0]         wdata_lane;
  logic [31:0]         rdata_ext;
  logic                access_err;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                unused_addr_bits;

  assign word_idx         = req_q.addr[DM_ADDRESS-1:2];
  assign rword            = mem[word_idx];
  assign unused_addr_bits = ^req_q.addr[REQ_ADDR_W-1:DM_ADDRESS];

  load_store_align u_align (
    .addr_lo    (req_q.addr[1:0]),
    .funct3     (req_q.funct3),
    .we         (req_q.we),
    .wdata      (req_q.wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .err        (access_err)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    rsp_done   = 1'b0;
    req_ready  = (state == IDLE) && !reset;
    rsp_valid  = (state == RESP);
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          state_next = WAIT;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (commit) begin
        rdata_q <= DATA_W'(rdata_ext);
        err_q   <= access_err;
      end else if (rsp_done) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Request fields are ignored outside IDLE; they are only sampled here.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      req_q.we     <= req_we;
      req_q.addr   <= REQ_ADDR_W'(req_addr);
      req_q.wdata  <= REQ_DATA_W'(req_wdata);
      req_q.funct3 <= req_funct3;
    end
  end

  // Storage has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (commit && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected responses are queued when a
// request is issued and popped when the responder presents rsp_valid.
module tb_data_mem_responder;

  localparam int DM_ADDRESS = 9;
  localparam int DATA_W     = 32;
  localparam int LATENCY    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DM_ADDRESS (DM_ADDRESS),
    .DATA_W     (DATA_W),
    .LATENCY    (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: issue, time the response, compare, optionally stall, handshake.
  task automatic access(input string tag, input logic we, input logic [8:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    exp_t e;
    exp_t got;
    int   n;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = 9'($urandom);
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(LATENCY));
    got = sb.pop_front();
    check({tag, " rdata"}, rsp_rdata, got.rdata);
    check({tag, " err"}, 32'(rsp_err), 32'(got.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold rdata"}, rsp_rdata, got.rdata);
      check({tag, " hold err"}, 32'(rsp_err), 32'(got.err));
      check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, " post valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " post rdata"}, rsp_rdata, 32'd0);
    check({tag, " post err"}, 32'(rsp_err), 32'd0);
    check({tag, " post req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = 3'b000;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle req_ready", 32'(req_ready), 32'd1);

    access("SW 010", 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 0);
    access("LW 010", 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 0);
    access("LB 013", 1'b0, 9'h013, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0, 0);
    access("LBU 013", 1'b0, 9'h013, 32'h0, 3'b100, 32'h000000DE, 1'b0, 0);
    access("LH 012", 1'b0, 9'h012, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0, 0);
    access("LHU 010", 1'b0, 9'h010, 32'h0, 3'b101, 32'h0000BEEF, 1'b0, 0);
    access("SB 011", 1'b1, 9'h011, 32'h00000055, 3'b000, 32'h0, 1'b0, 0);
    access("LW 010 after SB", 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 0);
    access("LW 012 misaligned", 1'b0, 9'h012, 32'h0, 3'b010, 32'h0, 1'b1, 0);
    access("SH 011 misaligned", 1'b1, 9'h011, 32'h00001234, 3'b001, 32'h0, 1'b1, 0);
    access("LW 010 unchanged", 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 0);
    access("load f3 011", 1'b0, 9'h010, 32'h0, 3'b011, 32'h0, 1'b1, 0);
    access("LW 010 stall", 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 5);
    access("SH 012", 1'b1, 9'h012, 32'h00007A5C, 3'b001, 32'h0, 1'b0, 0);
    access("LH 012 positive", 1'b0, 9'h012, 32'h0, 3'b001, 32'h00007A5C, 1'b0, 0);

    access("SW 020 seed", 1'b1, 9'h020, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 9'h020;
    req_wdata  = 32'h11111111;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    check("abort req_ready in reset", 32'(req_ready), 32'd0);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("abort no response", 32'(rsp_valid), 32'd0);
    end
    access("LW 020 after abort", 1'b0, 9'h020, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 0);

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 9'h010;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("resp drop reached RESP", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("resp drop valid", 32'(rsp_valid), 32'd0);
    check("resp drop rdata", rsp_rdata, 32'd0);
    check("resp drop err", 32'(rsp_err), 32'd0);
    access("LW 010 final", 1'b0, 9'h010, 32'h0, 3'b010, 32'h7A5C55EF, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
